// File: rtl/writeback_ctrl.sv
// Multicycle register-file writeback sequencer: SP init after reset, source wait, xchg double write.
// Optional WAIT timeout abort enabled by defining WB_TIMEOUT_EN.
module writeback_ctrl #(
   parameter logic [4:0]  SP_REG         = 5'd29,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_req,
   input  logic [3:0] wb_src,
   input  logic [4:0] wb_dest,
   input  logic [4:0] wb_dest2,
   input  logic       mem_ready,
   input  logic       md_busy,
   output logic [3:0] memToRegmux,
   output logic       RegWrite,
   output logic [4:0] WriteReg,
   output logic       wb_ack,
   output logic       wb_err,
   output logic       xchg_phase,
   output logic       busy
);

   // ABORT covers both an illegal source and a WAIT timeout.
   typedef enum logic [2:0] {INIT_SP, IDLE, WAIT, WRITE, XCHG2, ABORT} state_t;

   state_t     state_q, state_d;
   logic [3:0] src_q, src_d;
   logic [4:0] dest_q, dest_d;
   logic [4:0] dest2_q, dest2_d;
   logic       accept;
   logic       src_ready;
   logic       timeout;

`ifdef WB_TIMEOUT_EN
   localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);
   logic [4:0] wait_cnt_q;
   assign timeout = (wait_cnt_q == TO_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      accept  = (state_q == IDLE) && wb_req;
      src_d   = accept ? wb_src   : src_q;
      dest_d  = accept ? wb_dest  : dest_q;
      dest2_d = accept ? wb_dest2 : dest2_q;

      case (src_d)
         4'd1:       src_ready = mem_ready;
         4'd2, 4'd3: src_ready = ~md_busy;
         default:    src_ready = 1'b1;
      endcase

      state_d = state_q;
      case (state_q)
         // Reset leaves RegWrite low; the first post-reset edge shows the SP write, the next leaves.
         INIT_SP: state_d = RegWrite ? IDLE : INIT_SP;
         IDLE: begin
            if (accept) begin
               if (src_d >= 4'd9)  state_d = ABORT;
               else if (src_ready) state_d = WRITE;
               else                state_d = WAIT;
            end
         end
         WAIT: begin
            if (src_ready)    state_d = WRITE;
            else if (timeout) state_d = ABORT;
         end
         WRITE:   state_d = (src_q == 4'd8) ? XCHG2 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT_SP;
         src_q       <= '0;
         dest_q      <= '0;
         dest2_q     <= '0;
         memToRegmux <= '0;
         RegWrite    <= 1'b0;
         WriteReg    <= '0;
         wb_ack      <= 1'b0;
         wb_err      <= 1'b0;
         xchg_phase  <= 1'b0;
         busy        <= 1'b1;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dest_q      <= dest_d;
         dest2_q     <= dest2_d;
         memToRegmux <= '0;
         RegWrite    <= 1'b0;
         WriteReg    <= '0;
         wb_ack      <= 1'b0;
         wb_err      <= 1'b0;
         xchg_phase  <= 1'b0;
         busy        <= 1'b1;
         case (state_d)
            INIT_SP: begin
               memToRegmux <= 4'd9;
               RegWrite    <= 1'b1;
               WriteReg    <= SP_REG;
            end
            IDLE: busy <= 1'b0;
            WRITE: begin
               memToRegmux <= src_d;
               WriteReg    <= dest_d;
               RegWrite    <= (dest_d != '0);
               wb_ack      <= (src_d != 4'd8);
            end
            XCHG2: begin
               memToRegmux <= 4'd8;
               WriteReg    <= dest2_q;
               RegWrite    <= (dest2_q != '0);
               xchg_phase  <= 1'b1;
               wb_ack      <= 1'b1;
            end
            ABORT: begin
               wb_ack <= 1'b1;
               wb_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef WB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset || state_q != WAIT) wait_cnt_q <= '0;
      else                          wait_cnt_q <= wait_cnt_q + 5'd1;
   end
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: stimulus queues expected write/ack events, a monitor checks them.
module tb_writeback_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       wb_req;
   logic [3:0] wb_src;
   logic [4:0] wb_dest;
   logic [4:0] wb_dest2;
   logic       mem_ready;
   logic       md_busy;
   logic [3:0] memToRegmux;
   logic       RegWrite;
   logic [4:0] WriteReg;
   logic       wb_ack;
   logic       wb_err;
   logic       xchg_phase;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] mux;
      logic       rw;
      logic [4:0] wr;
      logic       ack;
      logic       err;
      logic       xp;
      bit         addr_care;
   } exp_t;

   exp_t sb[$];

   writeback_ctrl #(.SP_REG(5'd29), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src),
      .wb_dest(wb_dest), .wb_dest2(wb_dest2), .mem_ready(mem_ready),
      .md_busy(md_busy), .memToRegmux(memToRegmux), .RegWrite(RegWrite),
      .WriteReg(WriteReg), .wb_ack(wb_ack), .wb_err(wb_err),
      .xchg_phase(xchg_phase), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] mux, input logic rw, input logic [4:0] wr,
                       input logic ack, input logic err, input logic xp, input bit care);
      exp_t e;
      e.mux = mux; e.rw = rw; e.wr = wr; e.ack = ack; e.err = err; e.xp = xp; e.addr_care = care;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      if (busy) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic req(input logic [3:0] s, input logic [4:0] d, input logic [4:0] d2);
      wb_req = 1'b1; wb_src = s; wb_dest = d; wb_dest2 = d2;
      step();
      wb_req = 1'b0; wb_src = 4'd0; wb_dest = 5'd0; wb_dest2 = 5'd0;
   endtask

   // Monitor: every cycle presenting a write or an ack must match the next queued event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && wb_err && !wb_ack) chk("err_without_ack", 1, 0);
         if (!reset && (RegWrite || wb_ack)) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", {memToRegmux, RegWrite, WriteReg, wb_ack, wb_err}, -1);
            end else begin
               e = sb.pop_front();
               checks++;
               if (RegWrite !== e.rw || wb_ack !== e.ack || wb_err !== e.err || xchg_phase !== e.xp ||
                   (e.addr_care && (memToRegmux !== e.mux || WriteReg !== e.wr))) begin
                  errors++;
                  $display("FAIL event: got mux=%0d rw=%0d wr=%0d ack=%0d err=%0d xp=%0d expected mux=%0d rw=%0d wr=%0d ack=%0d err=%0d xp=%0d",
                           memToRegmux, RegWrite, WriteReg, wb_ack, wb_err, xchg_phase,
                           e.mux, e.rw, e.wr, e.ack, e.err, e.xp);
               end
            end
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1; wb_req = 1'b0; wb_src = 4'd0; wb_dest = 5'd0; wb_dest2 = 5'd0;
      mem_ready = 1'b0; md_busy = 1'b0;
      push(4'd9, 1'b1, 5'd29, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step();
      chk("reset_busy", busy, 1);
      chk("reset_regwrite", RegWrite, 0);
      reset = 1'b0;
      step();
      chk("init_mux", memToRegmux, 9);
      chk("init_writereg", WriteReg, 29);
      chk("init_busy", busy, 1);
      step();
      chk("idle_busy", busy, 0);
      chk("idle_regwrite", RegWrite, 0);

      // Simple ALU result writeback, latency 1
      push(4'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd0, 5'd8, 5'd0);
      chk("write_busy", busy, 1);
      step();
      chk("after_write_busy", busy, 0);

      // Load waits three cycles for mem_ready
      push(4'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd1, 5'd9, 5'd0);
      chk("wait_busy", busy, 1);
      step(); step();
      chk("wait3_regwrite", RegWrite, 0);
      mem_ready = 1'b1;
      step();
      chk("load_ack", wb_ack, 1);
      mem_ready = 1'b0;
      step();
      mem_ready = 1'b1; md_busy = 1'b1;
      step(); step();
      mem_ready = 1'b0; md_busy = 1'b0;
      wait_idle();

      // lo from mult/div while busy
      md_busy = 1'b1;
`ifdef WB_TIMEOUT_EN
      push(4'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      req(4'd3, 5'd10, 5'd0);
      n = 0;
      while (!wb_ack && n < 40) begin
         step();
         n++;
      end
      chk("timeout_wait_cycles", n, 16);
      chk("timeout_err", wb_err, 1);
      md_busy = 1'b0;
`else
      push(4'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd3, 5'd10, 5'd0);
      repeat (20) step();
      chk("md_wait_busy", busy, 1);
      md_busy = 1'b0;
      step();
      chk("md_write_mux", memToRegmux, 3);
`endif
      wait_idle();

      // hi with mult/div idle is ready immediately
      push(4'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd2, 5'd11, 5'd0);
      wait_idle();

      // xchg: two writes, ack on the second
      push(4'd8, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      push(4'd8, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      req(4'd8, 5'd4, 5'd5);
      chk("xchg1_ack", wb_ack, 0);
      step();
      chk("xchg2_phase", xchg_phase, 1);
      chk("xchg2_writereg", WriteReg, 5);
      wait_idle();

      // xchg with identical destinations still writes twice
      push(4'd8, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
      push(4'd8, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
      req(4'd8, 5'd6, 5'd6);
      wait_idle();

      // Illegal sources rejected, including the boundary code 9
      push(4'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      req(4'd12, 5'd7, 5'd0);
      chk("reject_busy", busy, 1);
      wait_idle();
      push(4'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      req(4'd9, 5'd7, 5'd0);
      wait_idle();

      // Write to $zero suppressed but acked
      push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd0, 5'd0, 5'd0);
      wait_idle();

      // Highest legal plain source, back-to-back requests
      push(4'd7, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd7, 5'd31, 5'd0);
      step();
      chk("b2b_idle", busy, 0);
      push(4'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd5, 5'd1, 5'd0);
      wait_idle();

      // Reset while waiting abandons the request silently
      mem_ready = 1'b0;
      req(4'd1, 5'd12, 5'd0);
      reset = 1'b1;
      step();
      chk("rst_mux", memToRegmux, 0);
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_writereg", WriteReg, 0);
      chk("rst_ack", wb_ack, 0);
      chk("rst_err", wb_err, 0);
      chk("rst_xchg", xchg_phase, 0);
      chk("rst_busy", busy, 1);
      push(4'd9, 1'b1, 5'd29, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      step();
      chk("reinit_mux", memToRegmux, 9);
      step();
      chk("reinit_idle", busy, 0);
      mem_ready = 1'b1;
      push(4'd6, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);
      req(4'd6, 5'd13, 5'd0);
      repeat (4) step();
      chk("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
